// File: rtl/adder_pipe_nb_if.sv
// adder_pipe_nb_if: handshake bundle for the pipelined adder/subtractor.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, s, cout, ovf
// Modports:
//   slave  - the adder itself (takes operands, produces results)
//   master - the environment (supplies operands, consumes results)
interface adder_pipe_nb_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_nb.sv
// adder_pipe_nb: N-bit adder/subtractor whose carry chain is cut into S
// registered segments of W = N/S bits. One operand pair per clock,
// valid/ready on both sides, whole pipeline stalls together.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - adder_pipe_nb_if.slave
//          in:  in_valid, a, b, cin, sub, out_ready
//          out: in_ready, out_valid, s, cout, ovf
// Result of an operand pair captured at edge t is presented after edge t+S-1.
module adder_pipe_nb #(
  parameter int N = 16,
  parameter int S = 4
) (
  input logic            clk,
  input logic            rst,
  adder_pipe_nb_if.slave bus
);
  localparam int W = N / S;

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c0;

  // Per-stage state. a_rem/b_rem hold the not-yet-added upper segments,
  // shifted down so the next segment to add always sits in bits [W-1:0].
  logic         valid_reg  [S];
  logic         carry_reg  [S];
  logic [N-1:0] sum_reg    [S];
  logic [N-1:0] a_rem_reg  [S];
  logic [N-1:0] b_rem_reg  [S];
  logic         a_sign_reg [S];
  logic         b_sign_reg [S];
  logic         ovf_reg;

  // Whole pipeline moves when the output slot is empty or being taken.
  assign adv          = bus.out_ready | ~valid_reg[S-1];
  assign bus.in_ready = adv;

  // Subtract is a + ~b + 1: invert b and force the carry-in.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    logic         src_valid;
    logic         src_carry;
    logic         src_a_sign;
    logic         src_b_sign;
    logic [N-1:0] src_a;
    logic [N-1:0] src_b;
    logic [N-1:0] src_sum;
    logic [W-1:0] seg_sum;
    logic         seg_carry;
    logic [N-1:0] sum_next;

    if (gi == 0) begin : g_src_in
      assign src_valid  = bus.in_valid;
      assign src_carry  = c0;
      assign src_a      = bus.a;
      assign src_b      = b_eff;
      assign src_a_sign = bus.a[N-1];
      assign src_b_sign = b_eff[N-1];
      assign src_sum    = '0;
    end else begin : g_src_prev
      assign src_valid  = valid_reg[gi-1];
      assign src_carry  = carry_reg[gi-1];
      assign src_a      = a_rem_reg[gi-1];
      assign src_b      = b_rem_reg[gi-1];
      assign src_a_sign = a_sign_reg[gi-1];
      assign src_b_sign = b_sign_reg[gi-1];
      assign src_sum    = sum_reg[gi-1];
    end

    assign {seg_carry, seg_sum} = {1'b0, src_a[W-1:0]} + {1'b0, src_b[W-1:0]}
                                + {{W{1'b0}}, src_carry};

    // The new segment enters at the top and earlier ones slide down by W,
    // so after the last stage segment 0 lands in bits [W-1:0].
    assign sum_next = (src_sum >> W) | (N'(seg_sum) << (N - W));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg[gi]  <= 1'b0;
        carry_reg[gi]  <= 1'b0;
        sum_reg[gi]    <= '0;
        a_rem_reg[gi]  <= '0;
        b_rem_reg[gi]  <= '0;
        a_sign_reg[gi] <= 1'b0;
        b_sign_reg[gi] <= 1'b0;
      end else if (adv) begin
        valid_reg[gi]  <= src_valid;
        carry_reg[gi]  <= seg_carry;
        sum_reg[gi]    <= sum_next;
        a_rem_reg[gi]  <= src_a >> W;
        b_rem_reg[gi]  <= src_b >> W;
        a_sign_reg[gi] <= src_a_sign;
        b_sign_reg[gi] <= src_b_sign;
      end
    end

    // Overflow needs the final sign bit, so it is resolved in the last stage
    // from the operand signs that travelled alongside the data.
    if (gi == S - 1) begin : g_ovf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= (src_a_sign == src_b_sign) & (sum_next[N-1] != src_a_sign);
        end
      end
    end
  end

  assign bus.out_valid = valid_reg[S-1];
  assign bus.s         = sum_reg[S-1];
  assign bus.cout      = carry_reg[S-1];
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_adder_pipe_nb.sv
// tb_adder_pipe_nb: drives three builds (S=4, S=1, S=16) with identical
// operands; each build has its own in-order expected-result ring filled from
// an integer-arithmetic model whenever that build accepts an operand pair.
module tb_adder_pipe_nb;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  always #5 clk = ~clk;

  adder_pipe_nb_if #(.N(N)) bif4 ();
  adder_pipe_nb_if #(.N(N)) bif1 ();
  adder_pipe_nb_if #(.N(N)) bif16 ();

  adder_pipe_nb #(.N(N), .S(4))  dut4  (.clk(clk), .rst(rst), .bus(bif4.slave));
  adder_pipe_nb #(.N(N), .S(1))  dut1  (.clk(clk), .rst(rst), .bus(bif1.slave));
  adder_pipe_nb #(.N(N), .S(16)) dut16 (.clk(clk), .rst(rst), .bus(bif16.slave));

  assign bif4.in_valid = in_valid;   assign bif1.in_valid = in_valid;   assign bif16.in_valid = in_valid;
  assign bif4.a = a;                 assign bif1.a = a;                 assign bif16.a = a;
  assign bif4.b = b;                 assign bif1.b = b;                 assign bif16.b = b;
  assign bif4.cin = cin;             assign bif1.cin = cin;             assign bif16.cin = cin;
  assign bif4.sub = sub;             assign bif1.sub = sub;             assign bif16.sub = sub;
  assign bif4.out_ready = out_ready; assign bif1.out_ready = out_ready; assign bif16.out_ready = out_ready;

  logic        ov [3];
  logic        ir [3];
  logic        oc [3];
  logic        oo [3];
  logic [15:0] os [3];
  assign ov[0] = bif4.out_valid; assign ov[1] = bif1.out_valid; assign ov[2] = bif16.out_valid;
  assign ir[0] = bif4.in_ready;  assign ir[1] = bif1.in_ready;  assign ir[2] = bif16.in_ready;
  assign oc[0] = bif4.cout;      assign oc[1] = bif1.cout;      assign oc[2] = bif16.cout;
  assign oo[0] = bif4.ovf;       assign oo[1] = bif1.ovf;       assign oo[2] = bif16.ovf;
  assign os[0] = bif4.s;         assign os[1] = bif1.s;         assign os[2] = bif16.s;

  logic [17:0] exp_mem [3][256];
  int wr_ptr [3];
  int rd_ptr [3];
  int stages [3];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int run_cnt, run_first, run_last;

  // {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] fa, input logic [15:0] fb,
                                            input logic fc, input logic fs);
    int ua, ub, sa, sb, ur, sr;
    logic co, vf;
    ua = int'(fa);
    ub = int'(fb);
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    if (fs) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(fc);
      sr = sa + sb + int'(fc);
      co = (ur > 65535);
    end
    vf = (sr > 32767) || (sr < -32768);
    return {vf, co, ur[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: note transfers before the edge, then check every visible result.
  task automatic tick();
    logic ixf [3];
    logic oxf [3];
    logic [17:0] e;
    #1;
    for (int d = 0; d < 3; d++) begin
      ixf[d] = in_valid & ir[d] & ~rst;
      oxf[d] = ov[d] & out_ready;
    end
    e = ref_model(a, b, cin, sub);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (ixf[d]) begin
        exp_mem[d][wr_ptr[d] % 256] = e;
        wr_ptr[d]++;
      end
      if (oxf[d]) rd_ptr[d]++;
      if (d == 0 && oxf[0]) begin
        if (run_cnt == 0) run_first = cyc;
        run_last = cyc;
        run_cnt++;
      end
      if (ov[d]) begin
        chk($sformatf("s%0d_result_pending", stages[d]), 32'(wr_ptr[d] > rd_ptr[d]), 32'd1);
        if (wr_ptr[d] > rd_ptr[d])
          chk($sformatf("s%0d_result_cyc%0d", stages[d], cyc), 32'({oo[d], oc[d], os[d]}),
              32'(exp_mem[d][rd_ptr[d] % 256]));
      end
    end
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic one(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                     input logic tc, input logic ts, input logic [17:0] expv);
    int n;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk(tag, 32'({oo[0], oc[0], os[0]}), 32'(expv));
  endtask

  initial begin
    int lat [3];
    int k;
    int acc_base [3];
    int min_acc;
    logic [17:0] hold_v;
    logic [17:0] first_v;

    stages = '{4, 1, 16};
    for (int d = 0; d < 3; d++) begin
      wr_ptr[d] = 0;
      rd_ptr[d] = 0;
    end
    run_cnt = 0; run_first = 0; run_last = 0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("s%0d_rst_out_valid", stages[d]), 32'(ov[d]), 32'd0);
      chk($sformatf("s%0d_rst_s", stages[d]), 32'(os[d]), 32'd0);
      chk($sformatf("s%0d_rst_cout", stages[d]), 32'(oc[d]), 32'd0);
      chk($sformatf("s%0d_rst_ovf", stages[d]), 32'(oo[d]), 32'd0);
      chk($sformatf("s%0d_rst_in_ready", stages[d]), 32'(ir[d]), 32'd1);
    end

    // Full carry ripple through all segments, latency per build
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = '{-1, -1, -1};
    first_v = '0;
    for (int t = 0; t < 24; t++) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && lat[d] < 0) begin
          lat[d] = t;
          if (d == 0) first_v = {oo[0], oc[0], os[0]};
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      tick();
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("s%0d_latency", stages[d]), 32'(lat[d]), 32'(stages[d] - 1));
    chk("ffff_plus_1", 32'(first_v), 32'h10000);
    drain(20);

    // Signed overflow / subtract corner cases
    one("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    one("5_minus_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    one("8000_minus_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    drain(20);

    // Back-to-back stream of 8 pairs
    run_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a = 16'(i); b = 16'(i * 16'h1000); cin = i[0]; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("stream_count", 32'(run_cnt), 32'd8);
    chk("stream_no_gap", 32'(run_last - run_first), 32'd7);
    drain(20);

    // Back-pressure: hold out_ready low for 3 cycles with a result waiting
    k = 0;
    in_valid = 1'b1;
    do begin
      a = 16'(16'h0100 + k); b = 16'(3 * k); cin = 1'b1; sub = k[0];
      tick();
      k++;
    end while (!ov[0] && k < 12);
    chk("stall_fill_valid", 32'(ov[0]), 32'd1);
    hold_v = {oo[0], oc[0], os[0]};
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a = 16'(16'h0100 + k); b = 16'(3 * k); sub = k[0];
      k++;
      #1;
      chk($sformatf("stall%0d_in_ready", j), 32'(ir[0]), 32'd0);
      tick();
      chk($sformatf("stall%0d_hold", j), 32'({oo[0], oc[0], os[0]}), 32'(hold_v));
      chk($sformatf("stall%0d_valid", j), 32'(ov[0]), 32'd1);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      a = 16'(16'h0100 + k); b = 16'(3 * k); sub = k[0];
      k++;
      tick();
    end
    drain(25);
    for (int d = 0; d < 3; d++)
      chk($sformatf("s%0d_stall_all_delivered", stages[d]), 32'(wr_ptr[d] - rd_ptr[d]), 32'd0);

    // Reset with items in flight
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'(16'h2000 + i); b = 16'(16'h0011 * i); cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(ov[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_s", 32'(os[0]), 32'd0);
    chk("midrst_cout", 32'(oc[0]), 32'd0);
    chk("midrst_ovf", 32'(oo[0]), 32'd0);
    for (int d = 0; d < 3; d++) rd_ptr[d] = wr_ptr[d];
    tick();
    rst = 1'b0;
    repeat (20) tick();
    one("post_rst_first", 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    drain(20);

    // Random traffic with random back-pressure on all three builds
    for (int d = 0; d < 3; d++) acc_base[d] = wr_ptr[d];
    min_acc = 0;
    for (int n = 0; n < 6000 && min_acc < 1000; n++) begin
      case ($urandom_range(0, 7))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        2: a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'hFFFF;
        1: b = 16'h8000;
        2: b = 16'h0001;
        default: b = 16'($urandom);
      endcase
      cin = 1'($urandom);
      sub = 1'($urandom);
      in_valid = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 8);
      tick();
      min_acc = wr_ptr[0] - acc_base[0];
      for (int d = 1; d < 3; d++)
        if (wr_ptr[d] - acc_base[d] < min_acc) min_acc = wr_ptr[d] - acc_base[d];
    end
    drain(40);
    chk("random_1000_vectors", 32'(min_acc >= 1000), 32'd1);
    for (int d = 0; d < 3; d++)
      chk($sformatf("s%0d_random_all_delivered", stages[d]), 32'(wr_ptr[d] - rd_ptr[d]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
